led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised multi-channel successor to the single free-running LED blinker.
- Drives NUM_CH LED outputs. Each channel has its own runtime-selectable mode: OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- One shared prescaler produces a slow tick for blink timing. Configuration is written one channel at a time through a single-cycle write port, typically from a CPU peripheral register or a top-level constant driver.

Parameters:
- NUM_CH, 4, number of LED channels (1..16).
- PRESCALE, 5000, clk cycles per blink tick (>=2; 5000 at a 10 kHz oscillator gives 0.5 s ticks, i.e. a 1 Hz blink at half-period 1).
- PRESCALE_W, 24, prescaler counter width; must satisfy 2^PRESCALE_W > PRESCALE.
- CH_W, 2, width of cfg_ch; must satisfy 2^CH_W >= NUM_CH, minimum 1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one-cycle pulse per write.
- cfg_ch  in  CH_W  channel index being written.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_val  in  8  BLINK: half-period in ticks; PWM: duty in 1/256 units; ignored for OFF/ON.
- led  out  NUM_CH  LED drive, bit i = channel i, registered.
- tick  out  1  one-cycle pulse each prescaler wrap (debug/sync).

Behaviour:
- Reset (reset=1 at posedge):
  - prescaler=0, pwm_cnt=0, tick=0, led=0.
  - All channels: mode=OFF, val=0, blink counter=0, blink state=1.
  - Reset mid-operation aborts everything the same cycle; there are no partial states.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick=1 for exactly the one cycle after the counter holds PRESCALE-1, so the tick period is exactly PRESCALE cycles.
  - First tick appears PRESCALE cycles after reset deasserts.
- PWM counter: 8-bit, free-running, +1 every clk, wraps 255->0. Shared by all channels.
- Config write:
  - On a cycle with cfg_we=1 and cfg_ch<NUM_CH, the channel's mode and val are loaded, its blink counter is cleared and its blink state is set to 1.
  - cfg_ch>=NUM_CH: write ignored, no state changes.
  - No backpressure: every write is accepted.
  - A write that coincides with a tick on the same channel: the write wins and that tick is not counted for that channel.
  - Other channels are unaffected by the write.
- Per-channel next led value, registered, so led updates 1 cycle after the inputs it depends on:
  - OFF: 0.
  - ON: 1.
  - BLINK:
    - Effective half-period H = max(val,1).
    - On each tick, the counter increments. When it reaches H, the blink state toggles and the counter clears.
    - led = blink state.
    - Result: led holds each level for H ticks = H*PRESCALE cycles. The first level after a write is 1.
  - PWM:
    - led = (pwm_cnt < val).
    - val=0 gives constant 0. val=255 gives 1 for 255 of every 256 cycles. Period is 256 clk.
    - The blink counter is held at 0 while in PWM mode.
- Mode change between BLINK and PWM takes effect on the next cycle, with no glitch longer than 1 cycle.
- Widths: the blink counter is 8 bits, and the comparison with H is unsigned. The prescaler never exceeds PRESCALE-1.

Test Plan:
- Reset: PRESCALE=4, NUM_CH=4, hold reset 3 cycles -> led=4'b0000, tick=0. First tick occurs 4 cycles after release, then every 4 cycles. Assert reset mid-blink -> led=0 next cycle.
- ON/OFF/invalid: write ch1 mode=1 -> led[1]=1 one cycle later. Write ch1 mode=0 -> led[1]=0. With NUM_CH=3, write ch3 mode=1 -> no led change.
- BLINK: PRESCALE=4, ch0 mode=2 val=3 -> led[0]=1 for 12 cycles, 0 for 12 cycles, repeating. With val=0 -> toggles every tick (4 cycles).
- PWM: ch2 mode=3 val=64 -> exactly 64 ones per 256 cycles, aligned to pwm_cnt 0..63. val=0 -> never 1. val=255 -> 255/256 high.
- Collision: write ch0 BLINK val=2 in the same cycle a tick fires -> the counter restarts, and the first toggle lands 2 full ticks (8 cycles) later, not 1.
- Independence: 4 channels in different modes, then rewrite ch1 -> the waveforms of ch0, ch2 and ch3 are unchanged cycle-for-cycle against the reference model.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver.
// Every channel runs in one of four modes: OFF, ON, BLINK or PWM.
// A shared prescaler produces the blink tick.
// A shared 8-bit free-running counter is the PWM timebase.
// Configuration is written one channel per cycle through the cfg_* strobe port.

module led_pattern_gen #(
   parameter int NUM_CH     = 4,     // number of LED channels (1..16)
   parameter int PRESCALE   = 5000,  // clk cycles per blink tick (>= 2)
   parameter int PRESCALE_W = 24,    // prescaler width, 2**PRESCALE_W > PRESCALE
   parameter int CH_W       = 2      // cfg_ch width, 2**CH_W >= NUM_CH
) (
   input  logic              clk,
   input  logic              reset,     // synchronous, active-high
   input  logic              cfg_we,    // one-cycle write strobe
   input  logic [CH_W-1:0]   cfg_ch,    // channel being written
   input  logic [1:0]        cfg_mode,  // 0=OFF 1=ON 2=BLINK 3=PWM
   input  logic [7:0]        cfg_val,   // BLINK half-period / PWM duty
   output logic [NUM_CH-1:0] led,       // registered LED drive
   output logic              tick       // one-cycle pulse per prescaler wrap
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_t;

   localparam logic [PRESCALE_W-1:0] LP_PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

   // ---------------------------------------------------------------
   // Shared timebase
   // ---------------------------------------------------------------
   logic [PRESCALE_W-1:0] r_presc;
   logic                  r_tick;
   logic [7:0]            r_pwm_cnt;
   logic                  w_presc_wrap;

   assign w_presc_wrap = (r_presc == LP_PRESC_MAX);

   // Prescaler counts 0..PRESCALE-1.
   // tick is the registered wrap flag, so it is high the cycle after the counter holds PRESCALE-1.
   // The PWM counter free-runs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_pwm_cnt <= '0;
      end else begin
         r_presc   <= w_presc_wrap ? '0 : r_presc + PRESCALE_W'(1);
         r_tick    <= w_presc_wrap;
         r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------
   // Configuration write decode
   // ---------------------------------------------------------------
   logic              w_ch_valid;
   logic [NUM_CH-1:0] w_cfg_hit;

   // One-hot write select.
   // An out-of-range channel index selects nothing, so the write is dropped.
   always_comb begin
      w_ch_valid = (int'(cfg_ch) < NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
         w_cfg_hit[i] = cfg_we && w_ch_valid && (int'(cfg_ch) == i);
      end
   end

   // ---------------------------------------------------------------
   // Per-channel state
   // ---------------------------------------------------------------
   mode_t             r_mode   [NUM_CH];
   logic [7:0]        r_val    [NUM_CH];
   logic [7:0]        r_bcnt   [NUM_CH];
   logic [NUM_CH-1:0] r_bstate;
   logic [NUM_CH-1:0] r_led;

   mode_t             w_mode_nxt   [NUM_CH];
   logic [7:0]        w_val_nxt    [NUM_CH];
   logic [7:0]        w_bcnt_nxt   [NUM_CH];
   logic [7:0]        w_half       [NUM_CH];
   logic [NUM_CH-1:0] w_bstate_nxt;
   logic [NUM_CH-1:0] w_led_nxt;

   // Effective blink half-period.
   // A value of 0 behaves as 1, so the LED never freezes in BLINK mode.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_half[i] = (r_val[i] == 8'd0) ? 8'd1 : r_val[i];
      end
   end

   // Next-state and next-LED logic per channel.
   // A write wins over a coincident tick.
   // The LED is computed from the post-edge mode, value and blink state.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         // NOTE: every combinational output gets a default first, so no path can infer a latch.
         w_mode_nxt[i]   = r_mode[i];
         w_val_nxt[i]    = r_val[i];
         w_bcnt_nxt[i]   = r_bcnt[i];
         w_bstate_nxt[i] = r_bstate[i];
         w_led_nxt[i]    = 1'b0;

         if (w_cfg_hit[i]) begin
            w_mode_nxt[i]   = mode_t'(cfg_mode);
            w_val_nxt[i]    = cfg_val;
            w_bcnt_nxt[i]   = 8'd0;
            w_bstate_nxt[i] = 1'b1;
         end else if (r_mode[i] == MODE_PWM) begin
            w_bcnt_nxt[i] = 8'd0;
         end else if ((r_mode[i] == MODE_BLINK) && r_tick) begin
            // Widen by one bit so the increment cannot wrap before the compare.
            if (({1'b0, r_bcnt[i]} + 9'd1) >= {1'b0, w_half[i]}) begin
               w_bcnt_nxt[i]   = 8'd0;
               w_bstate_nxt[i] = ~r_bstate[i];
            end else begin
               w_bcnt_nxt[i] = r_bcnt[i] + 8'd1;
            end
         end

         case (w_mode_nxt[i])
            MODE_OFF:   w_led_nxt[i] = 1'b0;
            MODE_ON:    w_led_nxt[i] = 1'b1;
            MODE_BLINK: w_led_nxt[i] = w_bstate_nxt[i];
            MODE_PWM:   w_led_nxt[i] = (r_pwm_cnt < w_val_nxt[i]);
            default:    w_led_nxt[i] = 1'b0;
         endcase
      end
   end

   // Per-channel registers and the LED output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the per-channel arrays are plain flops, not RAM, so they are cleared element by element.
         for (int i = 0; i < NUM_CH; i++) begin
            r_mode[i] <= MODE_OFF;
            r_val[i]  <= 8'd0;
            r_bcnt[i] <= 8'd0;
         end
         r_bstate <= '1;
         r_led    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_mode[i] <= w_mode_nxt[i];
            r_val[i]  <= w_val_nxt[i];
            r_bcnt[i] <= w_bcnt_nxt[i];
         end
         r_bstate <= w_bstate_nxt;
         r_led    <= w_led_nxt;
      end
   end

   assign led  = r_led;
   assign tick = r_tick;

endmodule
